// File: rtl/spi_reg_responder.sv
// spi_reg_responder
// SPI mode-0 slave that decodes command/data frames from an SPI master and
// turns them into single-cycle register-bus reads and writes on clk.
// ss_n, sclk and mosi are oversampled in the clk domain; nothing is clocked
// by sclk. Frame layout: byte0 = {rw, addr[6:0]} (rw=1 read), then data bytes
// until ss_n rises. Reads are prefetched one byte ahead so the next MISO byte
// is ready before the master's first rising edge of that byte.
module spi_reg_responder #(
    parameter int         SYNC_STAGES = 2,
    parameter int         AUTO_INC    = 1,
    parameter logic [7:0] FILL_BYTE   = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ss_n,
    input  logic       sclk,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_tri,
    output logic [6:0] bus_addr,
    output logic       bus_we,
    output logic [7:0] bus_wdata,
    output logic       bus_re,
    input  logic [7:0] bus_rdata,
    output logic       busy,
    output logic       frame_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMD   = 2'd1,
        WDATA = 2'd2,
        RDATA = 2'd3
    } state_t;

    localparam bit INC_EN = (AUTO_INC != 0);

    state_t state;
    state_t next_state;

    // Synchronizer chains and edge-detect history
    logic [SYNC_STAGES-1:0] ss_sync;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   ss_s;
    logic                   sclk_s;
    logic                   mosi_s;
    logic                   ss_prev;
    logic                   sclk_prev;
    logic                   ss_fall;
    logic                   ss_rise;
    logic                   sclk_rise;
    logic                   sclk_fall;

    // Shift datapath
    logic [2:0]             bit_cnt;
    logic [6:0]             rx_shift;
    logic [7:0]             tx_shift;
    logic [7:0]             tx_data;
    logic                   byte_done;

    // Per-cycle control strobes decoded from state and edges
    logic                   frame_start;
    logic                   sample_en;
    logic                   shift_en;
    logic                   byte_last;
    logic                   cmd_done;
    logic                   wr_done;
    logic                   rd_done;
    logic                   abort_err;
    logic [7:0]             rx_byte;

    assign ss_s   = ss_sync[SYNC_STAGES-1];
    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    assign ss_fall   = ss_prev & ~ss_s;
    assign ss_rise   = ~ss_prev & ss_s;
    assign sclk_rise = ~sclk_prev & sclk_s;
    assign sclk_fall = sclk_prev & ~sclk_s;

    // Bring the asynchronous SPI pins into the clk domain; ss_n idles high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_sync   <= '1;
            sclk_sync <= '0;
            mosi_sync <= '0;
        end else begin
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
        end
    end

    // Remember last synchronized levels so edges become one-cycle strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_prev   <= 1'b1;
            sclk_prev <= 1'b0;
        end else begin
            ss_prev   <= ss_s;
            sclk_prev <= sclk_s;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next-state: ss_n rising always closes the frame, whatever the state
    always_comb begin
        next_state = state;
        if (ss_rise) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (ss_fall) next_state = CMD;
                CMD:     if (cmd_done) next_state = rx_byte[7] ? RDATA : WDATA;
                WDATA:   next_state = WDATA;
                RDATA:   next_state = RDATA;
                default: next_state = IDLE;
            endcase
        end
    end

    // FSM outputs: sclk edges count only inside an open frame, and an sclk edge
    // that coincides with the ss_n edge opening or closing the frame is dropped
    always_comb begin
        frame_start = 1'b0;
        sample_en   = 1'b0;
        shift_en    = 1'b0;
        byte_last   = 1'b0;
        cmd_done    = 1'b0;
        wr_done     = 1'b0;
        rd_done     = 1'b0;
        abort_err   = 1'b0;
        rx_byte     = {rx_shift, mosi_s};
        if (state == IDLE) begin
            frame_start = ss_fall;
        end else begin
            sample_en = sclk_rise & ~ss_rise;
            shift_en  = sclk_fall & ~ss_rise;
            byte_last = sample_en & (bit_cnt == 3'd7);
            abort_err = ss_rise & (bit_cnt != 3'd0);
        end
        cmd_done = byte_last & (state == CMD);
        wr_done  = byte_last & (state == WDATA);
        rd_done  = byte_last & (state == RDATA);
    end

    // Frame status: busy and MISO enable follow the synchronized select,
    // and a close with a partial byte pending raises a one-cycle error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy      <= 1'b0;
            miso_tri  <= 1'b1;
            frame_err <= 1'b0;
        end else begin
            frame_err <= abort_err;
            if (frame_start) begin
                busy     <= 1'b1;
                miso_tri <= 1'b0;
            end else if (ss_rise) begin
                busy     <= 1'b0;
                miso_tri <= 1'b1;
            end
        end
    end

    // Receive shifter: MSB-first sampling of mosi on each sclk rise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt  <= 3'd0;
            rx_shift <= 7'd0;
        end else begin
            if (frame_start || ss_rise) begin
                bit_cnt <= 3'd0;
            end else if (sample_en) begin
                bit_cnt  <= bit_cnt + 3'd1;
                rx_shift <= rx_byte[6:0];
            end
        end
    end

    // Transmit shifter: fill byte goes out during the command byte; on the
    // falling edge that ends a byte the prefetched read data is loaded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miso      <= 1'b0;
            tx_shift  <= 8'd0;
            byte_done <= 1'b0;
        end else begin
            if (frame_start) begin
                miso      <= FILL_BYTE[7];
                tx_shift  <= {FILL_BYTE[6:0], 1'b0};
                byte_done <= 1'b0;
            end else if (ss_rise) begin
                byte_done <= 1'b0;
            end else if (byte_last) begin
                byte_done <= 1'b1;
            end else if (shift_en) begin
                if (byte_done) begin
                    miso      <= tx_data[7];
                    tx_shift  <= {tx_data[6:0], 1'b0};
                    byte_done <= 1'b0;
                end else begin
                    miso     <= tx_shift[7];
                    tx_shift <= {tx_shift[6:0], 1'b0};
                end
            end
        end
    end

    // Register bus: address capture, write strobe, read prefetch and the
    // post-access address increment (wraps naturally at 7 bits)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_addr  <= 7'd0;
            bus_we    <= 1'b0;
            bus_wdata <= 8'd0;
            bus_re    <= 1'b0;
            tx_data   <= 8'd0;
        end else begin
            bus_we <= 1'b0;
            bus_re <= 1'b0;
            if (bus_re) begin
                tx_data <= bus_rdata;
            end
            if (cmd_done) begin
                bus_addr <= rx_byte[6:0];
                bus_re   <= rx_byte[7];
            end else if (rd_done) begin
                bus_addr <= INC_EN ? bus_addr + 7'd1 : bus_addr;
                bus_re   <= 1'b1;
            end else if (wr_done) begin
                bus_wdata <= rx_byte;
                bus_we    <= 1'b1;
            end else if (bus_we) begin
                bus_addr <= INC_EN ? bus_addr + 7'd1 : bus_addr;
            end
        end
    end

endmodule
